// File: rtl/track_aging_scheduler_pkg.sv
// rtl/track_aging_scheduler_pkg.sv - shared fusion constants and aging state encoding
package track_aging_scheduler_pkg;

  localparam int MAX_TRACKS     = 1024;
  localparam int TRACK_ID_WIDTH = 10;
  localparam int TRACK_WIDTH    = 512;

  // Last-update timestamp field inside a track record (shared with the track manager)
  localparam int TS_LSB   = 0;
  localparam int TS_WIDTH = 64;

  localparam int SCAN_LAT = 3;

  // 32-bit ms times 1000 fits in 42 bits without overflow
  localparam int TMO_WIDTH = 42;
  localparam logic [9:0] US_PER_MS = 10'd1000;

  typedef enum logic [2:0] {
    AGE_IDLE   = 3'd0,
    AGE_WAIT   = 3'd1,
    AGE_EVAL   = 3'd2,
    AGE_DELETE = 3'd3,
    AGE_DONE   = 3'd4
  } age_state_e;

endpackage

// File: rtl/track_aging_scheduler_if.sv
// rtl/track_aging_scheduler_if.sv - database scan/delete port and external delete requester bundle
interface track_aging_scheduler_if;
  import track_aging_scheduler_pkg::*;

  logic                      db_scan_start;
  logic                      db_scan_next;
  logic [TRACK_ID_WIDTH-1:0] db_scan_id;
  logic [TRACK_WIDTH-1:0]    db_scan_data;
  logic                      db_scan_valid_entry;

  logic [TRACK_ID_WIDTH-1:0] db_delete_id;
  logic                      db_delete_valid;
  logic                      db_delete_ready;

  logic [TRACK_ID_WIDTH-1:0] ext_delete_id;
  logic                      ext_delete_valid;
  logic                      ext_delete_ready;

  // Scheduler side
  modport master (
    output db_scan_start, db_scan_next, db_delete_id, db_delete_valid, ext_delete_ready,
    input  db_scan_id, db_scan_data, db_scan_valid_entry, db_delete_ready,
    input  ext_delete_id, ext_delete_valid
  );

  // Database and track manager side
  modport slave (
    input  db_scan_start, db_scan_next, db_delete_id, db_delete_valid, ext_delete_ready,
    output db_scan_id, db_scan_data, db_scan_valid_entry, db_delete_ready,
    output ext_delete_id, ext_delete_valid
  );

endinterface

// File: rtl/track_aging_scheduler_age_cmp.sv
// rtl/track_aging_scheduler_age_cmp.sv - combinational stale-track test
module track_age_cmp
  import track_aging_scheduler_pkg::*;
(
  input  logic [TS_WIDTH-1:0]  ts,
  input  logic [TS_WIDTH-1:0]  now_snap,
  input  logic [TMO_WIDTH-1:0] tmo_us,
  input  logic                 valid,
  output logic                 stale
);

  logic [TS_WIDTH-1:0] age;

  // Future timestamps never age out; a zero timeout disables deletion
  always_comb begin
    age   = now_snap - ts;
    stale = valid && (tmo_us != '0) && (ts <= now_snap) && (age > TS_WIDTH'(tmo_us));
  end

endmodule

// File: rtl/track_aging_scheduler.sv
// rtl/track_aging_scheduler.sv - periodic stale-track sweep with shared delete port arbitration
module track_aging_scheduler
  import track_aging_scheduler_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_enable,
  input  logic [31:0]               cfg_period_cycles,
  input  logic [31:0]               cfg_timeout_ms,
  input  logic [63:0]               current_time,
  input  logic                      force_scan,
  track_aging_scheduler_if.master   db,
  output logic                      aged_valid,
  output logic [TRACK_ID_WIDTH-1:0] aged_id,
  output logic                      busy,
  output logic                      sweep_done,
  output logic [TRACK_ID_WIDTH:0]   sweep_aged,
  output logic [31:0]               total_aged
);

  localparam logic [2:0] S_IDLE   = AGE_IDLE;
  localparam logic [2:0] S_WAIT   = AGE_WAIT;
  localparam logic [2:0] S_EVAL   = AGE_EVAL;
  localparam logic [2:0] S_DELETE = AGE_DELETE;
  localparam logic [2:0] S_DONE   = AGE_DONE;

  localparam int WAIT_W = $clog2(SCAN_LAT + 1);
  localparam logic [WAIT_W-1:0] LAT_LAST = WAIT_W'(SCAN_LAT);
  localparam logic [TRACK_ID_WIDTH-1:0] LAST_ID = TRACK_ID_WIDTH'(MAX_TRACKS - 1);

  logic [2:0]                state;
  logic [31:0]               per_cnt;
  logic                      launch_pend;
  logic [63:0]               now_snap;
  logic [TMO_WIDTH-1:0]      tmo_us;
  logic [WAIT_W-1:0]         wait_cnt;
  logic [TRACK_ID_WIDTH-1:0] del_id;
  logic [TRACK_ID_WIDTH:0]   sweep_cnt;

  logic                      period_on;
  logic                      period_hit;
  logic                      stale;
  logic                      int_req;
  logic                      int_fire;
  logic                      advance;
  logic [TRACK_ID_WIDTH-1:0] adv_id;
  logic                      unused_payload;

  // Only the timestamp field of the record matters for aging
  assign unused_payload = ^db.db_scan_data[TRACK_WIDTH-1:TS_LSB+TS_WIDTH];

  track_age_cmp u_age_cmp (
    .ts       (db.db_scan_data[TS_LSB +: TS_WIDTH]),
    .now_snap (now_snap),
    .tmo_us   (tmo_us),
    .valid    (db.db_scan_valid_entry),
    .stale    (stale)
  );

  assign period_on  = cfg_enable && (cfg_period_cycles != 32'd0);
  assign period_hit = period_on && (per_cnt >= cfg_period_cycles - 32'd1);

  // External deletes own the port whenever they are valid; the internal request waits
  assign int_req  = (state == S_DELETE);
  assign int_fire = int_req && !db.ext_delete_valid && db.db_delete_ready;
  assign db.db_delete_valid  = db.ext_delete_valid | int_req;
  assign db.db_delete_id     = db.ext_delete_valid ? db.ext_delete_id : del_id;
  assign db.ext_delete_ready = db.db_delete_ready & (db.ext_delete_valid | ~int_req);

  assign busy    = (state != S_IDLE);
  assign advance = ((state == S_EVAL) && !stale) || int_fire;
  assign adv_id  = (state == S_DELETE) ? del_id : db.db_scan_id;

  // Free-running launch timer and the single collapsed launch request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt     <= 32'd0;
      launch_pend <= 1'b0;
    end else begin
      if (!period_on || period_hit) per_cnt <= 32'd0;
      else                          per_cnt <= per_cnt + 32'd1;
      if (period_hit || force_scan) launch_pend <= 1'b1;
      else if (state == S_IDLE)     launch_pend <= 1'b0;
    end
  end

  // Sweep sequencer: scan each slot, wait for the data, delete stale entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      now_snap         <= 64'd0;
      tmo_us           <= '0;
      wait_cnt         <= '0;
      del_id           <= '0;
      sweep_cnt        <= '0;
      db.db_scan_start <= 1'b0;
      db.db_scan_next  <= 1'b0;
      aged_valid       <= 1'b0;
      aged_id          <= '0;
      sweep_done       <= 1'b0;
      sweep_aged       <= '0;
      total_aged       <= 32'd0;
    end else begin
      db.db_scan_start <= 1'b0;
      db.db_scan_next  <= 1'b0;
      aged_valid       <= 1'b0;
      sweep_done       <= 1'b0;
      case (state)
        S_IDLE: if (launch_pend) begin
          now_snap         <= current_time;
          tmo_us           <= TMO_WIDTH'(cfg_timeout_ms) * TMO_WIDTH'(US_PER_MS);
          sweep_cnt        <= '0;
          wait_cnt         <= '0;
          db.db_scan_start <= 1'b1;
          state            <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == LAT_LAST) state <= S_EVAL;
          else                      wait_cnt <= wait_cnt + 1'b1;
        end
        S_EVAL: if (stale) begin
          del_id <= db.db_scan_id;
          state  <= S_DELETE;
        end
        S_DELETE: if (int_fire) begin
          aged_valid <= 1'b1;
          aged_id    <= del_id;
          sweep_cnt  <= sweep_cnt + 1'b1;
          if (total_aged != 32'hFFFF_FFFF) total_aged <= total_aged + 32'd1;
        end
        S_DONE: begin
          sweep_aged <= sweep_cnt;
          sweep_done <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (advance) begin
        if (adv_id == LAST_ID) begin
          state <= S_DONE;
        end else begin
          db.db_scan_next <= 1'b1;
          wait_cnt        <= '0;
          state           <= S_WAIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_track_aging_scheduler.sv
// tb/tb_track_aging_scheduler.sv - self-checking bench for the track aging scheduler
module tb_track_aging_scheduler;
  import track_aging_scheduler_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n;
  logic                      cfg_enable;
  logic [31:0]               cfg_period_cycles;
  logic [31:0]               cfg_timeout_ms;
  logic [63:0]               current_time;
  logic                      force_scan;
  logic                      aged_valid;
  logic [TRACK_ID_WIDTH-1:0] aged_id;
  logic                      busy;
  logic                      sweep_done;
  logic [TRACK_ID_WIDTH:0]   sweep_aged;
  logic [31:0]               total_aged;

  track_aging_scheduler_if dbif ();

  track_aging_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_enable        (cfg_enable),
    .cfg_period_cycles (cfg_period_cycles),
    .cfg_timeout_ms    (cfg_timeout_ms),
    .current_time      (current_time),
    .force_scan        (force_scan),
    .db                (dbif),
    .aged_valid        (aged_valid),
    .aged_id           (aged_id),
    .busy              (busy),
    .sweep_done        (sweep_done),
    .sweep_aged        (sweep_aged),
    .total_aged        (total_aged)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [63:0] ts_mem [MAX_TRACKS];
  bit          vld_mem [MAX_TRACKS];

  int aged_q[$];
  int int_q[$];
  int xfer_q[$];
  int done_q[$];
  int scan_cnt;
  int start_cyc;
  int next_gap;
  bit int_fire_prev;
  int int_id_prev;
  bit auto_on;
  longint unsigned exp_total;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Database model: answers a scan pulse SCAN_LAT cycles later, junk in between
  int unsigned scan_ptr = 0;
  int dly = 0;
  logic [TRACK_WIDTH-1:0] rec;
  always begin
    @(posedge clk);
    #1;
    if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        rec = {16{$urandom()}};
        rec[TS_LSB +: 64] = ts_mem[scan_ptr];
        dbif.db_scan_data        = rec;
        dbif.db_scan_id          = TRACK_ID_WIDTH'(scan_ptr);
        dbif.db_scan_valid_entry = vld_mem[scan_ptr];
      end
    end
    if (dbif.db_scan_start || dbif.db_scan_next) begin
      scan_ptr = dbif.db_scan_start ? 0 : (scan_ptr + 1) % MAX_TRACKS;
      dly = SCAN_LAT;
      dbif.db_scan_data        = {16{$urandom()}};
      dbif.db_scan_id          = TRACK_ID_WIDTH'($urandom());
      dbif.db_scan_valid_entry = 1'($urandom_range(0, 1));
    end
  end

  // Random external delete traffic and database back-pressure
  always begin
    @(posedge clk);
    #1;
    if (auto_on) begin
      if (dbif.ext_delete_valid && dbif.db_delete_ready) dbif.ext_delete_valid = 1'b0;
      if (!dbif.ext_delete_valid && $urandom_range(0, 7) == 0) begin
        dbif.ext_delete_valid = 1'b1;
        dbif.ext_delete_id    = TRACK_ID_WIDTH'($urandom());
      end
      dbif.db_delete_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Port arbitration, transfer log and notification timing
  always @(negedge clk) begin
    if (dbif.ext_delete_valid) begin
      check_val("arb_valid", dbif.db_delete_valid, 1);
      check_val("arb_id", dbif.db_delete_id, dbif.ext_delete_id);
      check_val("arb_ready", dbif.ext_delete_ready, dbif.db_delete_ready);
    end else if (dbif.db_delete_valid) begin
      check_val("ext_blocked", dbif.ext_delete_ready, 0);
    end
    if (dbif.db_delete_valid && dbif.db_delete_ready) begin
      if (dbif.ext_delete_valid) xfer_q.push_back(10000 + int'(dbif.db_delete_id));
      else begin
        xfer_q.push_back(int'(dbif.db_delete_id));
        int_q.push_back(int'(dbif.db_delete_id));
      end
    end
    if (aged_valid || int_fire_prev) begin
      check_val("aged_follow", aged_valid, int_fire_prev);
      if (aged_valid) begin
        check_val("aged_id_follow", aged_id, int_id_prev);
        aged_q.push_back(int'(aged_id));
      end
    end
    int_fire_prev = dbif.db_delete_valid && dbif.db_delete_ready && !dbif.ext_delete_valid;
    int_id_prev   = int'(dbif.db_delete_id);
    if (dbif.db_scan_start) begin
      scan_cnt  = 1;
      start_cyc = cyc;
    end else if (dbif.db_scan_next) begin
      if (scan_cnt == 1) next_gap = cyc - start_cyc;
      scan_cnt++;
    end
    if (sweep_done) done_q.push_back(int'(sweep_aged));
  end

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_scan_start"}, dbif.db_scan_start, 0);
    check_val({tag, "_scan_next"}, dbif.db_scan_next, 0);
    check_val({tag, "_del_valid"}, dbif.db_delete_valid, 0);
    check_val({tag, "_del_id"}, dbif.db_delete_id, 0);
    check_val({tag, "_ext_ready"}, dbif.ext_delete_ready, 0);
    check_val({tag, "_aged_valid"}, aged_valid, 0);
    check_val({tag, "_aged_id"}, aged_id, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_sweep_done"}, sweep_done, 0);
    check_val({tag, "_sweep_aged"}, sweep_aged, 0);
    check_val({tag, "_total_aged"}, total_aged, 0);
  endtask

  task automatic fill_db(input bit vld, input logic [63:0] ts);
    for (int i = 0; i < MAX_TRACKS; i++) begin
      vld_mem[i] = vld;
      ts_mem[i]  = ts;
    end
  endtask

  task automatic clear_logs();
    aged_q.delete();
    int_q.delete();
    xfer_q.delete();
    done_q.delete();
    scan_cnt = 0;
    next_gap = 0;
  endtask

  // Launch one forced sweep and compare against the age rule applied to the database
  task automatic run_sweep(input string tag, input logic [63:0] now, input logic [31:0] tmo_ms);
    int exp_q[$];
    longint unsigned tmo;
    int k;
    tmo = longint'(tmo_ms) * 1000;
    for (int i = 0; i < MAX_TRACKS; i++)
      if (vld_mem[i] && tmo != 0 && ts_mem[i] <= now && (now - ts_mem[i]) > tmo) exp_q.push_back(i);
    clear_logs();
    current_time   = now;
    cfg_timeout_ms = tmo_ms;
    force_scan     = 1'b1;
    step();
    force_scan = 1'b0;
    k = 0;
    while (!dbif.db_scan_start && k < 10) begin
      step();
      k++;
    end
    check_val({tag, "_start_seen"}, dbif.db_scan_start, 1);
    current_time   = {$urandom(), $urandom()};
    cfg_timeout_ms = $urandom();
    k = 0;
    while (done_q.size() == 0 && k < 20000) begin
      step();
      k++;
    end
    check_val({tag, "_done_seen"}, done_q.size(), 1);
    check_val({tag, "_aged_cnt"}, aged_q.size(), exp_q.size());
    check_val({tag, "_del_cnt"}, int_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < aged_q.size(); i++)
      check_val({tag, "_aged_id"}, aged_q[i], exp_q[i]);
    for (int i = 0; i < exp_q.size() && i < int_q.size(); i++)
      check_val({tag, "_del_id"}, int_q[i], exp_q[i]);
    if (done_q.size() > 0) check_val({tag, "_sweep_aged"}, done_q[0], exp_q.size());
    check_val({tag, "_scan_cnt"}, scan_cnt, MAX_TRACKS);
    check_val({tag, "_slot_gap"}, next_gap, SCAN_LAT + 2);
    exp_total += exp_q.size();
    check_val({tag, "_total"}, total_aged, exp_total);
    check_val({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [63:0] now;
    longint unsigned tmo_us;
    int n;

    rst_n             = 1'b0;
    cfg_enable        = 1'b0;
    cfg_period_cycles = 32'd0;
    cfg_timeout_ms    = 32'd0;
    current_time      = 64'd0;
    force_scan        = 1'b0;
    auto_on           = 1'b0;
    exp_total         = 0;
    dbif.db_scan_id          = '0;
    dbif.db_scan_data        = '0;
    dbif.db_scan_valid_entry = 1'b0;
    dbif.db_delete_ready     = 1'b0;
    dbif.ext_delete_valid    = 1'b0;
    dbif.ext_delete_id       = '0;
    fill_db(1'b0, 64'd0);

    step(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    step(2);
    check_outputs_zero("post_reset");
    dbif.db_delete_ready = 1'b1;

    // Aged, young, future and exact-boundary slots
    fill_db(1'b0, 64'd0);
    vld_mem[5]  = 1; ts_mem[5]  = 64'd1_000_000;
    vld_mem[9]  = 1; ts_mem[9]  = 64'd39_000_000;
    vld_mem[12] = 1; ts_mem[12] = 64'd41_000_000;
    vld_mem[20] = 1; ts_mem[20] = 64'd10_000_000;
    vld_mem[21] = 1; ts_mem[21] = 64'd9_999_999;
    ts_mem[30]  = 64'd0;
    run_sweep("basic", 64'd40_000_000, 32'd30000);

    // Zero timeout never deletes
    fill_db(1'b1, 64'd0);
    run_sweep("tmo_zero", 64'd40_000_000, 32'd0);

    // External delete arrives while internal delete of id 7 is stalled
    fill_db(1'b0, 64'd0);
    vld_mem[7] = 1;
    dbif.db_delete_ready = 1'b0;
    fork
      run_sweep("ext_prio", 64'd40_000_000, 32'd1);
      begin
        n = 0;
        while (!dbif.db_delete_valid && n < 8000) begin
          step();
          n++;
        end
        check_val("ext_prio_pending_id", dbif.db_delete_id, 7);
        step(3);
        dbif.ext_delete_id    = 10'd3;
        dbif.ext_delete_valid = 1'b1;
        dbif.db_delete_ready  = 1'b1;
        step();
        dbif.ext_delete_valid = 1'b0;
        dbif.ext_delete_id    = '0;
      end
    join
    check_val("ext_prio_xfers", xfer_q.size(), 2);
    if (xfer_q.size() == 2) begin
      check_val("ext_prio_first", xfer_q[0], 10003);
      check_val("ext_prio_second", xfer_q[1], 7);
    end

    // Periodic launch timing, then forced requests during a sweep collapse into one
    fill_db(1'b1, 64'd0);
    cfg_timeout_ms = 32'd0;
    clear_logs();
    cfg_period_cycles = 32'd100;
    cfg_enable = 1'b1;
    n = 0;
    while (!dbif.db_scan_start && n < 500) begin
      step();
      n++;
    end
    check_val("period_first_launch", n, 101);
    cfg_enable = 1'b0;
    step(200);
    force_scan = 1'b1; step(); force_scan = 1'b0;
    step(300);
    force_scan = 1'b1; step(); force_scan = 1'b0;
    step(50);
    force_scan = 1'b1; step(); force_scan = 1'b0;
    n = 0;
    while (done_q.size() < 2 && n < 15000) begin
      step();
      n++;
    end
    step(300);
    check_val("period_sweeps", done_q.size(), 2);
    check_val("period_idle", busy, 0);
    check_val("period_total", total_aged, exp_total);

    // Random database contents with random external traffic and back-pressure
    for (int s = 0; s < 2; s++) begin
      now    = {24'd0, $urandom(), 8'd0};
      tmo_us = longint'($urandom_range(1, 40000)) * 1000;
      for (int i = 0; i < MAX_TRACKS; i++) begin
        vld_mem[i] = 1'($urandom_range(0, 1));
        ts_mem[i]  = now + tmo_us / 2 - longint'($urandom_range(0, 32'(2 * tmo_us)));
      end
      vld_mem[100] = 1; ts_mem[100] = now - tmo_us;
      vld_mem[101] = 1; ts_mem[101] = now - tmo_us - 1;
      auto_on = 1'b1;
      run_sweep("random", now, 32'(tmo_us / 1000));
      auto_on = 1'b0;
      step(2);
      dbif.ext_delete_valid = 1'b0;
      dbif.db_delete_ready  = 1'b1;
      step();
    end

    // Reset while a delete is stalled, then a fresh sweep from slot 0
    fill_db(1'b0, 64'd0);
    vld_mem[2] = 1;
    dbif.db_delete_ready = 1'b0;
    current_time   = 64'd40_000_000;
    cfg_timeout_ms = 32'd1;
    force_scan = 1'b1; step(); force_scan = 1'b0;
    n = 0;
    while (!dbif.db_delete_valid && n < 200) begin
      step();
      n++;
    end
    check_val("rst_pending", dbif.db_delete_valid, 1);
    rst_n = 1'b0;
    step();
    check_outputs_zero("rst_mid");
    step();
    rst_n = 1'b1;
    exp_total = 0;
    scan_cnt = 0;
    step(5);
    check_val("rst_no_pulse", scan_cnt, 0);
    check_val("rst_idle", busy, 0);
    dbif.db_delete_ready = 1'b1;
    run_sweep("rst_rescan", 64'd40_000_000, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/track_aging_scheduler.md
# track_aging_scheduler

Background maintenance controller for the fusion track database: periodically sweeps all track slots through the database scan port, detects tracks whose last-update timestamp exceeds the configured timeout, and deletes them through the database delete port. The database's delete port is shared with an external requester (the track manager); this block arbitrates the port, giving external deletes priority. It sits between the track manager and the track database in the fusion pipeline and implements automatic stale-track deletion [REQ-FUSION-009].

## Interface
- MAX_TRACKS, 1024, track slots in the database
- TRACK_ID_WIDTH, 10, slot index width
- TRACK_WIDTH, 512, track record width
- TS_LSB, 0, bit offset of the 64-bit last-update timestamp (GPS µs) inside a record
- SCAN_LAT, 3, cycles from a scan_start/scan_next pulse until db_scan_id/data/valid_entry are stable

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_enable  in  1  enables periodic sweeps
- cfg_period_cycles  in  32  cycles between sweep launches; 0 disables periodic launch
- cfg_timeout_ms  in  32  age limit; 0 means never delete
- current_time  in  64  GPS microseconds
- force_scan  in  1  one-cycle request for an immediate sweep
- db_scan_start, db_scan_next  out  1  one-cycle pulses to the database scan port
- db_scan_id  in  TRACK_ID_WIDTH  scanned slot index
- db_scan_data  in  TRACK_WIDTH  scanned record
- db_scan_valid_entry  in  1  slot is occupied
- db_delete_id  out  TRACK_ID_WIDTH; db_delete_valid  out  1; db_delete_ready  in  1  database delete port
- ext_delete_id  in  TRACK_ID_WIDTH; ext_delete_valid  in  1; ext_delete_ready  out  1  external delete requester
- aged_valid  out  1; aged_id  out  TRACK_ID_WIDTH  one-cycle notification per aged-out track
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at sweep end
- sweep_aged  out  TRACK_ID_WIDTH+1  deletions in the last completed sweep
- total_aged  out  32  saturating lifetime deletion count

## Operation
- Period counter: counts while cfg_enable && cfg_period_cycles!=0; reaching cfg_period_cycles-1 sets launch_pend and restarts. force_scan also sets launch_pend. Multiple requests while pending or busy collapse into one.
- States:
  - IDLE: on launch_pend, snapshot now_snap=current_time and tmo_us=cfg_timeout_ms*1000 (42-bit, no overflow), clear launch_pend and the sweep counter, pulse db_scan_start, go to WAIT.
  - WAIT: count SCAN_LAT cycles, then go to EVAL.
  - EVAL: ts=db_scan_data[TS_LSB+:64]. Stale = db_scan_valid_entry && tmo_us!=0 && ts<=now_snap && (now_snap-ts)>tmo_us (64-bit unsigned). If stale, latch id and go to DELETE. Otherwise, if db_scan_id==MAX_TRACKS-1 go to DONE, else pulse db_scan_next and go to WAIT.
  - DELETE: present the latched id to the database, issuing when no external delete is pending. On an accepted transfer, pulse aged_valid/aged_id, increment the sweep counter and total_aged (saturating at 2^32-1), then continue as the non-stale EVAL path.
  - DONE: load sweep_aged, pulse sweep_done, go to IDLE.
- Arbitration: when ext_delete_valid=1, the database port carries the external id/valid and ext_delete_ready=db_delete_ready. Otherwise it carries the internal request and ext_delete_ready=0 only while an internal delete is in progress. No transfer is ever dropped or duplicated.
- cfg changes mid-sweep do not affect the sweep in progress (snapshots). Deasserting cfg_enable only blocks new periodic launches.

## Timing
- Reset values: all outputs 0; FSM IDLE; counters and launch_pend 0.
- First db_scan_start is issued 1 cycle after launch_pend is set.
- Per-slot cost without deletion: SCAN_LAT+2 cycles.
- A delete completes in the cycle where db_delete_valid && db_delete_ready. aged_valid follows 1 cycle later.
- busy=1 from the db_scan_start cycle through DONE.
- Reset mid-sweep aborts immediately and issues no further pulses.

## Structure
- Shared fusion package holds: the aging state enum, the TS_LSB/64-bit timestamp field constants (shared with the track manager), and the constant 1000 (µs per ms).
- Sub-module: track_age_cmp, a combinational stale test (ts, now_snap, tmo_us, valid → stale).

## Test plan
- Database with slots 5 (ts=1,000,000) and 9 (ts=39,000,000); now=40,000,000, timeout 30000 → only id 5 deleted, aged_valid id=5, sweep_aged=1.
- cfg_timeout_ms=0 with all slots stale → no deletions, sweep_done after 1024 entries, sweep_aged=0.
- ts=41,000,000 > now → not deleted (future timestamp).
- ext_delete_valid held during an internal delete of id 7 with ext id 3 → id 3 transfers first, then id 7, each exactly once.
- cfg_period_cycles=100 plus force_scan during a sweep → exactly one extra sweep follows; counts match.
- rst_n asserted mid-DELETE → all outputs 0 next cycle; a new sweep after release rescans from id 0.
